md_unit: RTL
============

# md_unit

Parametrised multiply/divide unit for the EX stage, holding the HI/LO pair. It provides the following:
- fixed-latency multiply;
- an iterative restoring divider, one quotient bit per cycle;
- optional multiply-accumulate and multiply-subtract;
- mid-operation HI/LO overrides, used by mthi/mtlo;
- a cancel input, used for exception flush.

The pipeline stalls on `busy` and on any md instruction that arrives while `busy` is high.

## Interface
- `WIDTH`, 32: operand width and the width of HI and of LO.
- `MUL_LAT`, 5: multiply/accumulate busy cycles. Must be at least 1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: launch an operation using `md_op`, `md_signed`, `d1` and `d2`.
- `md_op` in 2: 00 mul, 01 div, 10 madd, 11 msub.
- `md_signed` in 1: 1 signed, 0 unsigned.
- `cancel` in 1: abort the in-flight operation.
- `ovrd` in 1: write `d1` into HI or LO.
- `ovrd_dest` in 1: 1 HI, 0 LO.
- `d1`, `d2` in WIDTH: operands. `d1` is the dividend and the override data.
- `busy` out 1: operation in flight.
- `hi`, `lo` out WIDTH: register contents.
- `ovrd_hi`, `ovrd_lo` out 1: the half was overridden this cycle, or earlier during the current operation. These drive forwarding and are combinational from `ovrd`.

## Operation
- **States.**
  - IDLE to MUL on `start` with op mul/madd/msub. MUL runs `MUL_LAT` cycles, then IDLE.
  - IDLE to DIV on `start` with op div. DIV runs WIDTH+1 cycles, then IDLE.
  - `cancel` in MUL or DIV returns to IDLE next edge.
- **Start.**
  - `start` is honoured only in IDLE with `cancel`=0. Otherwise it is ignored.
  - At the start edge, clear both sticky override flags.
- **Mul.**
  - Latch the full 2·WIDTH product at the start edge.
  - At the final edge, write HI to the upper half and LO to the lower half.
- **Madd/msub.**
  - At the final edge, {HI,LO} ← {hi,lo} ± product, modulo 2^(2·WIDTH).
  - {hi,lo} means the register values at that edge, including any earlier override.
- **Div.**
  - The start edge latches |d1|, |d2| and the result signs. Unsigned mode uses the raw operand values.
  - Edges 1..WIDTH each perform one restoring iteration.
  - Edge WIDTH+1 applies the sign correction and writes LO←quotient, HI←remainder.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
- **Divide by zero.** LO = all ones, HI = `d1`, in both signed and unsigned modes.
- **Signed overflow (MIN/−1).** LO = MIN, HI = 0.
- **Corner-case timing.** Divide-by-zero and MIN/−1 take the full latency.
- **Override.**
  - `ovrd` writes `d1` into the selected half at that edge, in any state.
  - If busy, it also sets that half's sticky flag.
  - The final write skips any half whose flag is set, or which is being overridden at that same edge.
  - The other half is still written.
- **Cancel.**
  - No HI/LO result write occurs.
  - An `ovrd` in the same cycle still applies.
- **Reset.** `hi`=0, `lo`=0, `busy`=0, flags=0, state IDLE. Reset applies mid-operation too, and the result is lost.

## Timing
- Start sampled at edge k: `busy`=1 from after k through edge k+L. L = `MUL_LAT` for mul/madd/msub, WIDTH+1 for div.
- HI/LO carry the result after edge k+L, and `busy`=0 in the same cycle. Back-to-back `start` is accepted at edge k+L+1.
- `cancel` at edge j (k<j≤k+L): `busy`=0 after j. A `start` is accepted at j+1.
- `cancel` at the final edge k+L also suppresses the write.
- `ovrd` during `busy` is never stalled.
- `ovrd_hi`/`ovrd_lo` behave as follows:
  - they go high combinationally in the cycle `ovrd` is asserted;
  - they stay high until the next accepted `start`.

## Configuration
- **`MD_ACCUM_EN` defined:** madd/msub are implemented as described.
- **`MD_ACCUM_EN` undefined:**
  - op 10/11 `start` is ignored: `busy` stays 0 and HI/LO are unchanged.
  - No accumulator adder is built.

## Test plan
WIDTH=32, MUL_LAT=5 unless noted.
- Signed mul 0xFFFFFFFE×3 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Unsigned mul of the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- Signed div −7/2 → `busy` for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Unsigned div 100/7 → LO=14, HI=2.
- Divide-by-zero and overflow:
  - divu 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234;
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, after 33 cycles.
- Mul 0x10000×0x10000 with `ovrd` HI=0xA5A5A5A5 at busy cycle 2 → `ovrd_hi`=1 from that cycle. Final HI=0xA5A5A5A5, LO=0. A second `start` clears the flag.
- Cancel and start interaction:
  - `cancel` at busy cycle 10 of a div with HI=LO=0x55 → `busy`=0 next cycle, HI/LO stay 0x55;
  - `start` while `busy` is ignored;
  - `start`+`cancel` in IDLE is ignored.
- Accumulate, with `MD_ACCUM_EN`:
  - HI=0, LO=0xFFFFFFFF, maddu 1×1 → HI=1, LO=0;
  - then msub 2×3 → HI=0, LO=0xFFFFFFFA.

  Without `MD_ACCUM_EN`, the same stimulus leaves `busy`=0 and HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit holding HI/LO: fixed-latency multiply, restoring divider, HI/LO overrides.
// Define MD_ACCUM_EN to build multiply-accumulate/subtract (md_op 10/11).
module md_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic             md_signed,
  input  logic             cancel,
  input  logic             ovrd,
  input  logic             ovrd_dest,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovrd_hi,
  output logic             ovrd_lo
);

  localparam int unsigned CntMax = (MUL_LAT - 1 > WIDTH) ? MUL_LAT - 1 : WIDTH;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]       rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic                   q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                   stk_hi_q, stk_hi_d, stk_lo_q, stk_lo_d;
`ifdef MD_ACCUM_EN
  logic                   acc_q, acc_d, sub_q, sub_d;
  logic [2*WIDTH-1:0]     acc_sum;
`endif

  logic                   accept, mul_ok, d1_neg, d2_neg;
  logic [WIDTH-1:0]       d1_abs, d2_abs, quo_fix, rem_fix, res_hi, res_lo;
  logic [2*WIDTH-1:0]     ext1, ext2, prod_full, mul_res;
  logic [WIDTH:0]         shifted, diff;
  logic                   res_we, ovr_h, ovr_l;

  assign busy    = (state_q != StIdle);
  assign accept  = (state_q == StIdle) && start && !cancel;
  assign ovr_h   = ovrd && ovrd_dest;
  assign ovr_l   = ovrd && !ovrd_dest;
  assign ovrd_hi = stk_hi_q || ovr_h;
  assign ovrd_lo = stk_lo_q || ovr_l;
  assign hi      = hi_q;
  assign lo      = lo_q;

`ifdef MD_ACCUM_EN
  assign mul_ok  = (md_op != 2'b01);
  assign acc_sum = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
  assign mul_res = acc_q ? acc_sum : prod_q;
`else
  assign mul_ok  = (md_op == 2'b00);
  assign mul_res = prod_q;
`endif

  assign d1_neg    = md_signed && d1[WIDTH-1];
  assign d2_neg    = md_signed && d2[WIDTH-1];
  assign d1_abs    = d1_neg ? -d1 : d1;
  assign d2_abs    = d2_neg ? -d2 : d2;
  // Sign-extending to 2*WIDTH makes the truncated unsigned product correct for both modes.
  assign ext1      = {{WIDTH{d1_neg}}, d1};
  assign ext2      = {{WIDTH{d2_neg}}, d2};
  assign prod_full = ext1 * ext2;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`ifdef MD_ACCUM_EN
    acc_d   = acc_q;
    sub_d   = sub_q;
`endif
    res_we  = 1'b0;
    res_hi  = '0;
    res_lo  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && md_op == 2'b01) begin
          state_d = StDiv;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = d1_abs;
          dvsr_d  = d2_abs;
          // Divide by zero keeps an all-ones quotient and |d1| remainder, giving HI = d1.
          q_neg_d = (d1_neg ^ d2_neg) && (d2 != '0);
          r_neg_d = d1_neg;
        end else if (accept && mul_ok) begin
          state_d = StMul;
          cnt_d   = '0;
          prod_d  = prod_full;
`ifdef MD_ACCUM_EN
          acc_d   = md_op[1];
          sub_d   = md_op[0];
`endif
        end
      end
      StMul: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (cnt_q == MulLast) begin
          state_d = StIdle;
          res_we  = 1'b1;
          res_hi  = mul_res[2*WIDTH-1:WIDTH];
          res_lo  = mul_res[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (cancel) begin
          state_d = StIdle;
        end else if (cnt_q == DivLast) begin
          state_d = StIdle;
          res_we  = 1'b1;
          res_hi  = rem_fix;
          res_lo  = quo_fix;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stk_hi_d = stk_hi_q;
    stk_lo_d = stk_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept && (md_op == 2'b01 || mul_ok)) begin
      stk_hi_d = 1'b0;
      stk_lo_d = 1'b0;
    end
    if (busy && ovr_h) stk_hi_d = 1'b1;
    if (busy && ovr_l) stk_lo_d = 1'b1;
    if (res_we && !stk_hi_q) hi_d = res_hi;
    if (res_we && !stk_lo_q) lo_d = res_lo;
    if (ovr_h) hi_d = d1;
    if (ovr_l) lo_d = d1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      stk_hi_q <= 1'b0;
      stk_lo_q <= 1'b0;
`ifdef MD_ACCUM_EN
      acc_q    <= 1'b0;
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      stk_hi_q <= stk_hi_d;
      stk_lo_q <= stk_lo_d;
`ifdef MD_ACCUM_EN
      acc_q    <= acc_d;
      sub_q    <= sub_d;
`endif
    end
  end

endmodule
